uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that multiplexes byte requesters onto one UART TX port
// and applies UART control-word updates only after the TX FIFO has drained and idled.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [15:0] GUARD_CYC  = 16'd4400,
    parameter logic [31:0] CTRL_RST   = 32'h0000_3510
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_vld_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    input  logic                          cfg_vld_i,
    input  logic [31:0]                   cfg_word_i,
    output logic                          cfg_rdy_o,
    output logic                          cfg_done_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_vld_o,
    input  logic                          tx_rdy_i,
    input  logic [31:0]                   uart_state_i,
    output logic [31:0]                   ctrl_o,
    output logic                          ctrl_enable_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        DRAIN = 3'd2,
        GUARD = 3'd3,
        APPLY = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [15:0]          guard_q, guard_d;
    logic [31:0]          word_q, word_d;
    logic [31:0]          ctrl_q, ctrl_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 cfg_rdy_q, cfg_rdy_d;
    logic                 cfg_done_q, cfg_done_d;
    logic                 ctrl_en_q, ctrl_en_d;

    logic                 arb_found;
    logic [PTR_W-1:0]     arb_idx;
    logic [PTR_W-1:0]     cand;
    logic                 fifo_empty;
    logic                 xfer_last;
    logic                 unused_state_bits;

    assign fifo_empty        = uart_state_i[1];
    assign unused_state_bits = ^{uart_state_i[31:2], uart_state_i[0]};

    // Round-robin search beginning one past the last granted requester
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!arb_found && req_vld_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Owner datapath is combinational so a ready owner can stream one byte per cycle
    always_comb begin
        tx_data_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                tx_data_o = tx_data_o | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign tx_vld_o  = (state_q == GRANT) && |(grant_q & req_vld_i);
    assign req_rdy_o = (state_q == GRANT) ? (grant_q & {NUM_REQ{tx_rdy_i}}) : '0;
    assign xfer_last = (state_q == GRANT) && tx_rdy_i && |(grant_q & req_vld_i & req_last_i);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        guard_d    = guard_q;
        word_d     = word_q;
        ctrl_d     = ctrl_q;
        grant_d    = grant_q;
        cfg_rdy_d  = 1'b0;
        cfg_done_d = 1'b0;
        ctrl_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_vld_i) begin
                    cfg_rdy_d = 1'b1;
                    word_d    = cfg_word_i;
                    state_d   = DRAIN;
                end else if (arb_found) begin
                    grant_d = NUM_REQ'(1) << arb_idx;
                    ptr_d   = arb_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer_last) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    guard_d = GUARD_CYC;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                // Any FIFO activity restarts the quiet period from DRAIN
                if (!fifo_empty) begin
                    state_d = DRAIN;
                end else if (guard_q == 16'd0) begin
                    ctrl_d     = word_q;
                    ctrl_en_d  = 1'b1;
                    cfg_done_d = 1'b1;
                    state_d    = APPLY;
                end else begin
                    guard_d = guard_q - 16'd1;
                end
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            guard_q    <= 16'd0;
            word_q     <= CTRL_RST;
            ctrl_q     <= CTRL_RST;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            cfg_rdy_q  <= 1'b0;
            cfg_done_q <= 1'b0;
            ctrl_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            guard_q    <= guard_d;
            word_q     <= word_d;
            ctrl_q     <= ctrl_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            cfg_rdy_q  <= cfg_rdy_d;
            cfg_done_q <= cfg_done_d;
            ctrl_en_q  <= ctrl_en_d;
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = busy_q;
    assign cfg_rdy_o     = cfg_rdy_q;
    assign cfg_done_o    = cfg_done_q;
    assign ctrl_o        = ctrl_q;
    assign ctrl_enable_o = ctrl_en_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level model checked every cycle plus
// hand-computed expectations for bursts, fairness and reconfiguration timing.
module tb_uart_tx_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam logic [15:0] GC = 16'd4;
    localparam logic [31:0] CR = 32'h0000_3510;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_vld_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_last_i;
    logic [NR-1:0]     req_rdy_o;
    logic              cfg_vld_i;
    logic [31:0]       cfg_word_i;
    logic              cfg_rdy_o;
    logic              cfg_done_o;
    logic [DW-1:0]     tx_data_o;
    logic              tx_vld_o;
    logic              tx_rdy_i;
    logic [31:0]       uart_state_i;
    logic [31:0]       ctrl_o;
    logic              ctrl_enable_o;
    logic [NR-1:0]     grant_o;
    logic              busy_o;

    uart_tx_sched #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .GUARD_CYC (GC),
        .CTRL_RST  (CR)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_vld_i    (req_vld_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_rdy_o    (req_rdy_o),
        .cfg_vld_i    (cfg_vld_i),
        .cfg_word_i   (cfg_word_i),
        .cfg_rdy_o    (cfg_rdy_o),
        .cfg_done_o   (cfg_done_o),
        .tx_data_o    (tx_data_o),
        .tx_vld_o     (tx_vld_o),
        .tx_rdy_i     (tx_rdy_i),
        .uart_state_i (uart_state_i),
        .ctrl_o       (ctrl_o),
        .ctrl_enable_o(ctrl_enable_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester byte queues: {data, last}
    logic [8:0] bq [NR][16];
    int         head [NR];
    int         tail [NR];

    // Scenario controls
    logic        tx_rdy_s, empty_s, cfg_vld_s;
    logic [31:0] cfg_word_s;

    // Inputs as seen at the upcoming edge
    logic [NR-1:0] s_vld, s_last, s_fire;
    logic          s_cfg_vld, s_tx_rdy, s_empty;
    logic [31:0]   s_cfg_word;

    // Model: mode 0 free, 1 owned, 2 waiting for empty FIFO, 3 quiet period, 4 applying
    int          m_mode, m_owner, m_ptr, m_gentry;
    logic [31:0] m_word, m_ctrl;
    logic        m_rdy, m_done, m_en;

    // Observed transfers
    int          lg_k [$];
    logic [7:0]  lg_d [$];
    int          lg_cyc [$];
    logic [3:0]  lg_g [$];
    int          en_count, en_cyc, rdy_cyc;

    logic [7:0]  exp1 [6];
    logic [7:0]  exp6 [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_owner = -1; m_ptr = NR - 1; m_gentry = 0;
        m_word = CR; m_ctrl = CR;
        m_rdy = 1'b0; m_done = 1'b0; m_en = 1'b0;
    endtask

    task automatic model_edge();
        bit found;
        m_rdy = 1'b0; m_done = 1'b0; m_en = 1'b0;
        case (m_mode)
            0: begin
                if (s_cfg_vld) begin
                    m_word = s_cfg_word; m_rdy = 1'b1; m_mode = 2;
                end else if (s_vld != '0) begin
                    found = 1'b0;
                    for (int n = 1; n <= NR; n++) begin
                        int c;
                        c = (m_ptr + n) % NR;
                        if (!found && s_vld[c]) begin
                            found = 1'b1; m_owner = c;
                        end
                    end
                    m_ptr = m_owner; m_mode = 1;
                end
            end
            1: if (s_vld[m_owner] && s_tx_rdy && s_last[m_owner]) begin
                m_owner = -1; m_mode = 0;
            end
            2: if (s_empty) begin
                m_gentry = cyc; m_mode = 3;
            end
            3: begin
                if (!s_empty) m_mode = 2;
                else if (cyc - m_gentry == int'(GC) + 1) begin
                    m_mode = 4; m_ctrl = m_word; m_en = 1'b1; m_done = 1'b1;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare();
        logic [NR-1:0] eg, er;
        logic          ev;
        eg = '0; er = '0; ev = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = req_vld_i[m_owner];
            if (tx_rdy_i) er[m_owner] = 1'b1;
        end
        check("grant_o", 32'(grant_o), 32'(eg));
        check("busy_o", 32'(busy_o), 32'(m_mode != 0));
        check("cfg_rdy_o", 32'(cfg_rdy_o), 32'(m_rdy));
        check("cfg_done_o", 32'(cfg_done_o), 32'(m_done));
        check("ctrl_enable_o", 32'(ctrl_enable_o), 32'(m_en));
        check("ctrl_o", ctrl_o, m_ctrl);
        check("tx_vld_o", 32'(tx_vld_o), 32'(ev));
        check("req_rdy_o", 32'(req_rdy_o), 32'(er));
        if (ev) check("tx_data_o", 32'(tx_data_o), 32'(req_data_i[m_owner*DW +: DW]));
        if (cfg_rdy_o) begin cfg_vld_s = 1'b0; rdy_cyc = cyc; end
        if (ctrl_enable_o) begin en_count++; en_cyc = cyc; end
    endtask

    task automatic drive();
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    v, l;
        d = '0; v = '0; l = '0;
        for (int k = 0; k < NR; k++) begin
            if (head[k] != tail[k]) begin
                v[k] = 1'b1;
                d[k*DW +: DW] = bq[k][head[k]][8:1];
                l[k] = bq[k][head[k]][0];
            end
        end
        req_vld_i = v; req_data_i = d; req_last_i = l;
        tx_rdy_i = tx_rdy_s;
        uart_state_i = {30'd0, empty_s, 1'b1};
        cfg_vld_i = cfg_vld_s;
        cfg_word_i = cfg_word_s;
    endtask

    task automatic sample();
        s_vld = req_vld_i; s_last = req_last_i; s_tx_rdy = tx_rdy_i;
        s_cfg_vld = cfg_vld_i; s_cfg_word = cfg_word_i; s_empty = uart_state_i[1];
        s_fire = req_vld_i & req_rdy_o;
        if (tx_vld_o && tx_rdy_i) begin
            int o;
            o = -1;
            for (int k = 0; k < NR; k++) if (grant_o[k]) o = k;
            lg_k.push_back(o); lg_d.push_back(tx_data_o);
            lg_cyc.push_back(cyc + 1); lg_g.push_back(grant_o);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        cyc++;
        if (!rst_i) begin
            for (int k = 0; k < NR; k++) if (s_fire[k]) head[k]++;
            model_edge();
        end
        #3; compare();
        #3; drive();
        #1; sample();
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic last);
        bq[k][tail[k]] = {d, last};
        tail[k]++;
    endtask

    task automatic clear_log();
        lg_k.delete(); lg_d.delete(); lg_cyc.delete(); lg_g.delete();
        en_count = 0; en_cyc = 0; rdy_cyc = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        @(posedge clk_i);
        cyc++;
        #6;
        rst_i = 1'b1;
        for (int k = 0; k < NR; k++) begin head[k] = 0; tail[k] = 0; end
        tx_rdy_s = 1'b1; empty_s = 1'b1; cfg_vld_s = 1'b0;
        model_reset();
        drive();
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ctrl", ctrl_o, 32'h0000_3510);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_en", 32'(ctrl_enable_o), 32'd0);
        sample();
        s_fire = '0;
        step();
        rst_i = 1'b0;
        sample();
        s_fire = '0;
        clear_log();
    endtask

    initial begin
        exp1 = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
        exp6 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        rst_i = 1'b1;
        tx_rdy_s = 1'b1; empty_s = 1'b1; cfg_vld_s = 1'b0; cfg_word_s = '0;
        for (int k = 0; k < NR; k++) begin head[k] = 0; tail[k] = 0; end
        model_reset();
        clear_log();
        drive();
        @(posedge clk_i);
        #7;
        check("init_grant", 32'(grant_o), 32'd0);
        check("init_busy", 32'(busy_o), 32'd0);
        check("init_cfg_rdy", 32'(cfg_rdy_o), 32'd0);
        check("init_done", 32'(cfg_done_o), 32'd0);
        check("init_en", 32'(ctrl_enable_o), 32'd0);
        check("init_ctrl", ctrl_o, 32'h0000_3510);
        check("init_tx_vld", 32'(tx_vld_o), 32'd0);
        rst_i = 1'b0;
        sample();
        s_fire = '0;

        // Two 3-byte bursts from requesters 0 and 2
        push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        for (int b = 0; b < 40 && lg_d.size() < 6; b++) step();
        check("s1_count", 32'(lg_d.size()), 32'd6);
        if (lg_d.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("s1_byte", 32'(lg_d[i]), 32'(exp1[i]));
                check("s1_grant", 32'(lg_g[i]), (i < 3) ? 32'h1 : 32'h4);
            end
            check("s1_stream", 32'(lg_cyc[2] - lg_cyc[0]), 32'd2);
            check("s1_bubble", 32'(lg_cyc[3] - lg_cyc[2]), 32'd2);
        end
        repeat (3) step();

        // Fairness with every requester sending single-byte bursts
        do_reset();
        for (int k = 0; k < NR; k++) begin
            push(k, 8'(8'h30 + k), 1'b1);
            push(k, 8'(8'h40 + k), 1'b1);
        end
        for (int b = 0; b < 80 && lg_d.size() < 8; b++) step();
        check("s2_count", 32'(lg_d.size()), 32'd8);
        if (lg_d.size() >= 5) begin
            check("s2_o0", 32'(lg_k[0]), 32'd0);
            check("s2_o1", 32'(lg_k[1]), 32'd1);
            check("s2_o2", 32'(lg_k[2]), 32'd2);
            check("s2_o3", 32'(lg_k[3]), 32'd3);
            check("s2_o4", 32'(lg_k[4]), 32'd0);
            check("s2_d4", 32'(lg_d[4]), 32'h40);
        end
        repeat (3) step();

        // Reconfiguration requested mid-burst of requester 1
        do_reset();
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b0); push(1, 8'h44, 1'b1);
        for (int b = 0; b < 20 && lg_d.size() < 1; b++) step();
        cfg_vld_s = 1'b1; cfg_word_s = 32'h0000_1B10;
        for (int b = 0; b < 60 && en_count < 1; b++) step();
        check("s3_en_seen", 32'(en_count), 32'd1);
        check("s3_bytes", 32'(lg_d.size()), 32'd4);
        if (lg_d.size() == 4) begin
            check("s3_owner", 32'(lg_k[3]), 32'd1);
            check("s3_last", 32'(lg_d[3]), 32'h44);
            check("s3_order", 32'(rdy_cyc > lg_cyc[3]), 32'd1);
        end
        check("s3_latency", 32'(en_cyc - rdy_cyc), 32'd6);
        check("s3_ctrl", ctrl_o, 32'h0000_1B10);
        repeat (5) step();
        check("s3_hold", ctrl_o, 32'h0000_1B10);
        check("s3_single", 32'(en_count), 32'd1);

        // FIFO activity during the quiet period restarts it
        do_reset();
        empty_s = 1'b0; cfg_vld_s = 1'b1; cfg_word_s = 32'h0000_2222;
        for (int b = 0; b < 20 && rdy_cyc == 0; b++) step();
        repeat (3) step();
        empty_s = 1'b1;
        repeat (3) step();
        empty_s = 1'b0;
        repeat (3) step();
        check("s4_no_early", 32'(en_count), 32'd0);
        check("s4_busy", 32'(busy_o), 32'd1);
        empty_s = 1'b1;
        begin
            int raise_edge;
            raise_edge = cyc + 2;
            for (int b = 0; b < 30 && en_count < 1; b++) step();
            check("s4_en_seen", 32'(en_count), 32'd1);
            check("s4_latency", 32'(en_cyc - raise_edge), 32'd5);
        end
        check("s4_ctrl", ctrl_o, 32'h0000_2222);

        // Reset during the quiet period abandons the update
        do_reset();
        cfg_vld_s = 1'b1; cfg_word_s = 32'h0000_5555;
        for (int b = 0; b < 20 && rdy_cyc == 0; b++) step();
        repeat (3) step();
        check("s5_busy_pre", 32'(busy_o), 32'd1);
        do_reset();
        repeat (20) step();
        check("s5_no_en", 32'(en_count), 32'd0);
        check("s5_ctrl", ctrl_o, 32'h0000_3510);

        // Back-pressure for 10 cycles mid-burst
        do_reset();
        for (int i = 0; i < 5; i++) push(3, exp6[i], i == 4);
        for (int b = 0; b < 20 && lg_d.size() < 2; b++) step();
        tx_rdy_s = 1'b0;
        repeat (10) step();
        check("s6_hold_grant", 32'(grant_o), 32'h8);
        check("s6_hold_data", 32'(tx_data_o), 32'h63);
        check("s6_hold_vld", 32'(tx_vld_o), 32'd1);
        check("s6_stalled", 32'(lg_d.size()), 32'd2);
        tx_rdy_s = 1'b1;
        for (int b = 0; b < 20 && lg_d.size() < 5; b++) step();
        repeat (5) step();
        check("s6_count", 32'(lg_d.size()), 32'd5);
        if (lg_d.size() == 5) begin
            for (int i = 0; i < 5; i++) check("s6_byte", 32'(lg_d[i]), 32'(exp6[i]));
            check("s6_gap", 32'(lg_cyc[2] - lg_cyc[1]), 32'd11);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
